// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RF_DATA_W   = 19;
  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_NUM_REGS = 20;
  localparam int unsigned RF_ZERO_REG = 0;
  localparam int unsigned RF_PC_REG   = 19;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_write_arb.sv
// Winning-write select for one queried address: among enabled, writable ports
// that target the address, the highest port index wins; two or more flag a conflict.
module rf_write_arb #(
  parameter int unsigned DATA_W   = 19,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 20,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned PC_REG   = 19
) (
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data,
  output logic                     conflict
);

  logic writable;

  // Writes to the zero register, the PC slot or unimplemented indices never land.
  always_comb begin
    writable = ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS)) &&
               (addr != ADDR_W'(ZERO_REG)) &&
               (addr != ADDR_W'(PC_REG));
  end

  // Ascending scan so the highest matching port overrides lower ones.
  always_comb begin
    int unsigned n;
    n        = 0;
    hit      = 1'b0;
    data     = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (we[i] && (wa[i*ADDR_W +: ADDR_W] == addr) && writable) begin
        hit  = 1'b1;
        data = wd[i*DATA_W +: DATA_W];
        n    = n + 1;
      end
    end
    conflict = (n >= 2);
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with sequenced clear, write->read bypass,
// prioritised multi-write, dedicated PC write channel and error flags.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = RF_ZERO_REG,
  parameter int unsigned PC_REG   = RF_PC_REG,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic                     pc_we,
  input  logic [DATA_W-1:0]        pc_wd,
  output logic [DATA_W-1:0]        pc_q,
  output logic                     ready,
  output logic                     wr_conflict,
  output logic                     addr_err
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              addr_err_q, addr_err_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [NUM_REGS-1:0] reg_hit, reg_conf;
  logic [DATA_W-1:0]   reg_wd [NUM_REGS];
  logic [NUM_RD-1:0]   rd_hit, rd_conf;
  logic [DATA_W-1:0]   rd_byp [NUM_RD];
  logic [DATA_W-1:0]   rd_v   [NUM_RD];
  logic                run;

  assign run = (state_q == RF_RUN);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg_arb
    rf_write_arb #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
      .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG), .PC_REG(PC_REG)
    ) u_arb (
      .we(we), .wa(wa), .wd(wd), .addr(ADDR_W'(r)),
      .hit(reg_hit[r]), .data(reg_wd[r]), .conflict(reg_conf[r])
    );
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_arb
    rf_write_arb #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
      .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG), .PC_REG(PC_REG)
    ) u_arb (
      .we(we), .wa(wa), .wd(wd), .addr(ra[p*ADDR_W +: ADDR_W]),
      .hit(rd_hit[p]), .data(rd_byp[p]), .conflict(rd_conf[p])
    );
  end

  // Next state: walk clr_idx through every register, then run; track out-of-range accesses.
  always_comb begin
    logic bad;
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    addr_err_d = addr_err_q;
    bad        = 1'b0;
    for (int unsigned i = 0; i < NUM_WR; i++)
      if (we[i] && ({1'b0, wa[i*ADDR_W +: ADDR_W]} >= (ADDR_W+1)'(NUM_REGS))) bad = 1'b1;
    for (int unsigned i = 0; i < NUM_RD; i++)
      if ({1'b0, ra[i*ADDR_W +: ADDR_W]} >= (ADDR_W+1)'(NUM_REGS)) bad = 1'b1;
    case (state_q)
      RF_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_W'(NUM_REGS-1)) begin
          state_d   = RF_RUN;
          clr_idx_d = '0;
        end
      end
      RF_RUN: if (bad) addr_err_d = 1'b1;
      default: state_d = RF_CLEAR;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RF_CLEAR;
      clr_idx_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Array update: clear one entry per cycle while clearing, else arbitrated writes plus PC.
  always_comb begin
    regs_d = regs_q;
    if (!run) begin
      regs_d[clr_idx_q] = '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        if (reg_hit[r]) regs_d[r] = reg_wd[r];
      if (pc_we) regs_d[PC_REG] = pc_wd;
    end
  end

  // Storage flops carry no reset; the clear sequence zeroes them.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Read ports: zero/out-of-range read as 0, bypass the winning write when enabled.
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] a;
      a       = ra[p*ADDR_W +: ADDR_W];
      rd_v[p] = '0;
      if (run && ({1'b0, a} < (ADDR_W+1)'(NUM_REGS)) && (a != ADDR_W'(ZERO_REG)))
        rd_v[p] = ((BYPASS != 0) && rd_hit[p]) ? rd_byp[p] : regs_q[a];
    end
  end

  // Output packing and status flags.
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++)
      rd[p*DATA_W +: DATA_W] = rd_v[p];
    pc_q        = run ? regs_q[PC_REG] : '0;
    ready       = run;
    // Read-port instances can only see conflicts the per-register ones also see.
    wr_conflict = run && ((|reg_conf) || (|rd_conf));
    addr_err    = addr_err_q;
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ra;
  logic [37:0] rd;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [37:0] wd;
  logic        pc_we;
  logic [18:0] pc_wd;
  logic [18:0] pc_q;
  logic        ready, wr_conflict, addr_err;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  register_file_mp #(
    .DATA_W(19), .ADDR_W(5), .NUM_REGS(20), .NUM_RD(2), .NUM_WR(2),
    .ZERO_REG(0), .PC_REG(19), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
    .pc_we(pc_we), .pc_wd(pc_wd), .pc_q(pc_q), .ready(ready),
    .wr_conflict(wr_conflict), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd0();
    return 32'(rd[18:0]);
  endfunction

  function automatic logic [31:0] rd1();
    return 32'(rd[37:19]);
  endfunction

  initial begin
    reset = 1'b1; ra = '0; we = '0; wa = '0; wd = '0; pc_we = 1'b0; pc_wd = '0;
    step();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_addr_err", 32'(addr_err), 0);
    chk("rst_pc_q", 32'(pc_q), 0);
    reset = 1'b0;
    ra = {5'd19, 5'd3};
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("clr_ready_%0d", i), 32'(ready), 0);
      chk($sformatf("clr_rd0_%0d", i), rd0(), 0);
      step();
    end
    chk("ready_up", 32'(ready), 1);
    for (int r = 0; r < 20; r++) begin
      ra = {5'd0, 5'(r)};
      #1;
      chk($sformatf("zero_r%0d", r), rd0(), 0);
    end

    // Single write with same-cycle bypass
    step();
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {19'd0, 19'h1234}; ra = {5'd0, 5'd5};
    #1;
    chk("byp_r5", rd0(), 32'h1234);
    step();
    we = 2'b00;
    #1;
    chk("stored_r5", rd0(), 32'h1234);

    // Two ports, same address: port 1 wins
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {19'h2, 19'h1}; ra = {5'd5, 5'd7};
    #1;
    chk("conf_pulse", 32'(wr_conflict), 1);
    chk("conf_byp", rd0(), 32'h2);
    chk("conf_rd1_r5", rd1(), 32'h1234);
    step();
    we = 2'b00;
    #1;
    chk("conf_clear", 32'(wr_conflict), 0);
    chk("conf_r7", rd0(), 32'h2);

    // Two ports, different addresses: both land, no conflict
    we = 2'b11; wa = {5'd9, 5'd10}; wd = {19'h4_5678, 19'h7_0001}; ra = {5'd10, 5'd9};
    #1;
    chk("dual_noconf", 32'(wr_conflict), 0);
    step();
    we = 2'b00;
    #1;
    chk("dual_r9", rd0(), 32'h4_5678);
    chk("dual_r10", rd1(), 32'h7_0001);

    // Discarded writes to zero and PC registers
    we = 2'b11; wa = {5'd19, 5'd0}; wd = {19'h55, 19'h7FFFF}; ra = {5'd19, 5'd0};
    #1;
    chk("wz_rd0", rd0(), 0);
    chk("wpc_nobyp", rd1(), 0);
    step();
    we = 2'b00;
    #1;
    chk("wz_r0", rd0(), 0);
    chk("wpc_pcq", 32'(pc_q), 0);
    pc_we = 1'b1; pc_wd = 19'h40;
    #1;
    chk("pc_nobyp_q", 32'(pc_q), 0);
    chk("pc_nobyp_rd", rd1(), 0);
    step();
    pc_we = 1'b0;
    #1;
    chk("pc_q", 32'(pc_q), 32'h40);
    chk("pc_rd", rd1(), 32'h40);
    chk("err_before", 32'(addr_err), 0);

    // Out-of-range read
    ra = {5'd0, 5'd25};
    #1;
    chk("oor_rd0", rd0(), 0);
    chk("oor_err_late", 32'(addr_err), 0);
    step();
    ra = {5'd0, 5'd5};
    #1;
    chk("oor_err_set", 32'(addr_err), 1);
    step(); step();
    chk("oor_err_sticky", 32'(addr_err), 1);
    chk("oor_r5", rd0(), 32'h1234);

    // Reset partway through clear; writes during clear are dropped
    reset = 1'b1;
    step();
    chk("rst2_err", 32'(addr_err), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    we = 2'b11; wa = {5'd5, 5'd5}; wd = {19'h3AAAA, 19'h11111};
    pc_we = 1'b1; pc_wd = 19'h777;
    ra = {5'd19, 5'd5};
    #1;
    chk("clr_noconf", 32'(wr_conflict), 0);
    chk("clr_rd0", rd0(), 0);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("rclr_ready_%0d", i), 32'(ready), 0);
      step();
    end
    we = 2'b00; pc_we = 1'b0;
    #1;
    chk("rclr_ready_up", 32'(ready), 1);
    chk("rclr_r5", rd0(), 0);
    chk("rclr_pc", 32'(pc_q), 0);
    chk("rclr_err", 32'(addr_err), 0);
    ra = {5'd10, 5'd7};
    #1;
    chk("rclr_r7", rd0(), 0);
    chk("rclr_r10", rd1(), 0);

    // Out-of-range write sets the error flag
    we = 2'b01; wa = {5'd0, 5'd30}; wd = {19'd0, 19'h1};
    step();
    we = 2'b00;
    #1;
    chk("oor_wr_err", 32'(addr_err), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
